// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: parity and stop-bit field encodings, transmit FSM
// states and the stop-length helper.
package uart_tx_fifo_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;

  localparam logic [1:0] STOP_1   = 2'b00;
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } txState_e;

  // Encoding 2'b11 shares the two-stop-bit length with STOP_2.
  function automatic int unsigned stopTicks(input logic [1:0] stopBits,
                                            input int unsigned sampleRate);
    case (stopBits)
      STOP_1:   stopTicks = sampleRate;
      STOP_1P5: stopTicks = (sampleRate * 3) / 2;
      default:  stopTicks = 2 * sampleRate;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo_fwft.sv
// First-word-fall-through FIFO: dout_o shows the head entry whenever empty_o is low.
// DEPTH must be a power of two so the pointers wrap on their own.
module fifo_fwft
  import uart_tx_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrEn_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rdEn_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doWrite;
  logic             doRead;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign doWrite = wrEn_i && !full_o;
  assign doRead  = rdEn_i && !empty_o;
  assign dout_o  = mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem_q[wrPtr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (doRead) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({doWrite, doRead})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a FWFT FIFO and are serialised
// LSB first as start, data, optional parity and stop bits.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int SAMPLE_RATE = 16,
  parameter int USE_PARITY  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_parity,
  input  logic [1:0]       cfg_stop_bits,
  input  logic [15:0]      cfg_clk_div,
  input  logic             tx_req,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx_busy,
  output logic             uart_tx
);

  localparam int SCW = $clog2(2 * SAMPLE_RATE);
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  txState_e         state_q;
  logic [15:0]      tickCnt_q;
  logic [15:0]      tickCnt_d;
  logic [SCW-1:0]   sampleCnt_q;
  logic [SCW-1:0]   lastSampleIdx;
  logic [BCW-1:0]   bitCnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shiftNext;
  logic             parityBit_q;
  logic             parityEn_q;
  logic [1:0]       stopCfg_q;
  logic             uartTx_q;

  logic [15:0]      clkDiv;
  logic             tick;
  logic             bitEnd;
  logic             fifoPop;
  logic             fifoEmpty;
  logic             fifoFull;
  logic [WIDTH-1:0] fifoDout;
  logic             parityEnNext;

  fifo_fwft #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wrEn_i (tx_req && tx_ready),
    .din_i  (tx_data),
    .rdEn_i (fifoPop),
    .dout_o (fifoDout),
    .empty_o(fifoEmpty),
    .full_o (fifoFull)
  );

  assign tx_ready = !fifoFull;
  assign tx_busy  = (state_q != ST_IDLE) || !fifoEmpty;
  assign uart_tx  = uartTx_q;

  // The divider is read live; >= keeps the tick regular if it shrinks mid-count.
  assign clkDiv    = (cfg_clk_div == 16'd0) ? 16'd1 : cfg_clk_div;
  assign tick      = (state_q != ST_IDLE) && (tickCnt_q >= (clkDiv - 16'd1));
  assign fifoPop   = (state_q == ST_IDLE) && !fifoEmpty;
  assign shiftNext = shift_q >> 1;
  assign bitEnd    = tick && (sampleCnt_q == lastSampleIdx);

  assign parityEnNext = (USE_PARITY != 0) &&
                        ((cfg_parity == PARITY_EVEN) || (cfg_parity == PARITY_ODD));

  always_comb begin
    lastSampleIdx = SCW'(SAMPLE_RATE - 1);
    if (state_q == ST_STOP) begin
      lastSampleIdx = SCW'(stopTicks(stopCfg_q, SAMPLE_RATE) - 1);
    end
  end

  // Held at zero in IDLE, so every START begins with a fresh tick period.
  always_comb begin
    tickCnt_d = tickCnt_q + 16'd1;
    if ((state_q == ST_IDLE) || tick) begin
      tickCnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tickCnt_q <= 16'd0;
    end else begin
      tickCnt_q <= tickCnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      sampleCnt_q <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      parityBit_q <= 1'b0;
      parityEn_q  <= 1'b0;
      stopCfg_q   <= STOP_1;
      uartTx_q    <= 1'b1;
    end else begin
      if (tick) begin
        sampleCnt_q <= bitEnd ? '0 : sampleCnt_q + SCW'(1);
      end
      unique case (state_q)
        ST_IDLE: begin
          uartTx_q <= 1'b1;
          if (fifoPop) begin
            shift_q     <= fifoDout;
            parityBit_q <= (^fifoDout) ^ (cfg_parity == PARITY_ODD);
            parityEn_q  <= parityEnNext;
            stopCfg_q   <= cfg_stop_bits;
            sampleCnt_q <= '0;
            bitCnt_q    <= '0;
            uartTx_q    <= 1'b0;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          if (bitEnd) begin
            uartTx_q <= shift_q[0];
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bitEnd) begin
            if (bitCnt_q == LAST_BIT) begin
              if (parityEn_q) begin
                uartTx_q <= parityBit_q;
                state_q  <= ST_PARITY;
              end else begin
                uartTx_q <= 1'b1;
                state_q  <= ST_STOP;
              end
            end else begin
              bitCnt_q <= bitCnt_q + BCW'(1);
              shift_q  <= shiftNext;
              uartTx_q <= shiftNext[0];
            end
          end
        end
        ST_PARITY: begin
          if (bitEnd) begin
            uartTx_q <= 1'b1;
            state_q  <= ST_STOP;
          end
        end
        ST_STOP: begin
          // A waiting word is popped from IDLE on the very next cycle.
          if (bitEnd) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          uartTx_q <= 1'b1;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a per-cycle line log is compared against
// frames rebuilt from the word, parity mode, stop mode and divider.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_parity;
  logic [1:0]  cfg_stop_bits;
  logic [15:0] cfg_clk_div;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_busy;
  logic        uart_tx;

  int nCompared   = 0;
  int nMismatched = 0;

  logic lineLog[$];
  logic busyLog[$];

  uart_tx_fifo #(
    .WIDTH(8),
    .FIFO_DEPTH(8),
    .SAMPLE_RATE(16),
    .USE_PARITY(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_parity   (cfg_parity),
    .cfg_stop_bits(cfg_stop_bits),
    .cfg_clk_div  (cfg_clk_div),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .uart_tx      (uart_tx)
  );

  always #5 clk = ~clk;

  // One sample per clock, taken on the falling edge.
  always @(negedge clk) begin
    lineLog.push_back(uart_tx);
    busyLog.push_back(tx_busy);
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pushes one word; idx is the log index of the cycle in which it sits at the FIFO head.
  task automatic applyStimulus(input logic [7:0] w, output int idx);
    tx_data = w;
    tx_req  = 1'b1;
    @(posedge clk);
    idx = lineLog.size();
    #1;
    tx_req = 1'b0;
  endtask

  task automatic waitLog(input int n);
    while (lineLog.size() < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitIdle(input string tag);
    int g = 0;
    while (tx_busy !== 1'b0 && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 5000) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: observed tx_busy=%b after 5000 cycles expected=0", tag, tx_busy);
    end
  endtask

  task automatic findStart(input string tag, input int from, input int limit, output int s);
    int i = from;
    s = -1;
    while (s < 0 && i < from + limit) begin
      waitLog(i + 1);
      if (lineLog[i] === 1'b0) s = i;
      else i++;
    end
    if (s < 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL %s: observed no start bit within %0d cycles expected start bit", tag, limit);
      s = from;
    end
  endtask

  task automatic checkSteady(input string tag, input int from, input int n, input logic lvl);
    logic aggLine;
    logic aggBusy;
    waitLog(from + n);
    aggLine = lineLog[from];
    aggBusy = busyLog[from];
    for (int k = 1; k < n; k++) begin
      if (lineLog[from + k] !== aggLine) aggLine = 1'bx;
      if (busyLog[from + k] !== aggBusy) aggBusy = 1'bx;
    end
    checkOutput({tag, " line"}, {31'b0, aggLine}, {31'b0, lvl});
    checkOutput({tag, " busy"}, {31'b0, aggBusy}, 32'd0);
  endtask

  // Reference frame: segment list of (level, clk cycles) built from the bit rules.
  task automatic checkFrame(input string tag, input int s, input logic [7:0] w,
                            input logic [1:0] par, input logic [1:0] stp,
                            input logic [15:0] div, output int len);
    int   d;
    int   stopTk;
    int   idx;
    logic pb;
    logic agg;
    logic lv[$];
    int   ln[$];
    d = (div == 16'd0) ? 1 : int'(div);
    lv.push_back(1'b0);
    ln.push_back(16 * d);
    for (int b = 0; b < 8; b++) begin
      lv.push_back(w[b]);
      ln.push_back(16 * d);
    end
    if (par == 2'b01 || par == 2'b10) begin
      pb = (($countones(w) % 2) == 1);
      if (par == 2'b10) pb = ~pb;
      lv.push_back(pb);
      ln.push_back(16 * d);
    end
    stopTk = (stp == 2'b00) ? 16 : (stp == 2'b01) ? 24 : 32;
    lv.push_back(1'b1);
    ln.push_back(stopTk * d);
    len = 0;
    foreach (ln[i]) len += ln[i];
    waitLog(s + len + 1);
    checkOutput({tag, " high before start"}, {31'b0, lineLog[s - 1]}, 32'd1);
    idx = s;
    for (int i = 0; i < lv.size(); i++) begin
      agg = lineLog[idx];
      for (int k = 1; k < ln[i]; k++) begin
        if (lineLog[idx + k] !== agg) agg = 1'bx;
      end
      checkOutput($sformatf("%s seg%0d", tag, i), {31'b0, agg}, {31'b0, lv[i]});
      idx += ln[i];
    end
  endtask

  initial begin
    int         p, p2, s, s2, len, len2, occ, firstIdx, prevS, prevEnd, rIdx;
    logic [7:0] wA, wB;
    logic [7:0] expQ[$];
    logic [1:0] newPar;
    logic [1:0] rPar, rStp;
    logic [15:0] rDiv;

    rst           = 1'b0;
    tx_req        = 1'b0;
    tx_data       = 8'h00;
    cfg_parity    = 2'b00;
    cfg_stop_bits = 2'b00;
    cfg_clk_div   = 16'd1;

    // Reset held for three clocks
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset uart_tx", {31'b0, uart_tx}, 32'd1);
    checkOutput("reset tx_ready", {31'b0, tx_ready}, 32'd1);
    checkOutput("reset tx_busy", {31'b0, tx_busy}, 32'd0);
    rst = 1'b1;
    checkSteady("post-reset idle", lineLog.size(), 500, 1'b1);

    // 0x55, no parity, one stop
    applyStimulus(8'h55, p);
    findStart("0x55 start", p, 50, s);
    checkOutput("0x55 start latency", s - p, 32'd1);
    checkFrame("0x55", s, 8'h55, 2'b00, 2'b00, 16'd1, len);
    checkOutput("0x55 busy last frame cycle", {31'b0, busyLog[s + len - 1]}, 32'd1);
    checkOutput("0x55 busy after frame", {31'b0, busyLog[s + len]}, 32'd0);

    // 0x07 even then odd parity, two stop, back to back
    waitIdle("idle before parity test");
    cfg_parity    = 2'b01;
    cfg_stop_bits = 2'b10;
    applyStimulus(8'h07, p);
    @(posedge clk);
    #1;
    cfg_parity = 2'b10;
    applyStimulus(8'h07, p2);
    findStart("even start", p, 50, s);
    checkOutput("even start latency", s - p, 32'd1);
    checkFrame("0x07 even", s, 8'h07, 2'b01, 2'b10, 16'd1, len);
    findStart("odd start", s + len, 100, s2);
    checkOutput("odd start gap", s2 - s, len + 1);
    checkFrame("0x07 odd", s2, 8'h07, 2'b10, 2'b10, 16'd1, len2);

    // Burst of ten pushes into an eight-deep FIFO at divider 4
    waitIdle("idle before burst");
    cfg_parity    = 2'b00;
    cfg_stop_bits = 2'b00;
    cfg_clk_div   = 16'd4;
    occ      = 0;
    firstIdx = 0;
    for (int i = 0; i < 10; i++) begin
      bit expReady;
      expReady = (occ < 8);
      tx_req   = 1'b1;
      tx_data  = 8'(i);
      checkOutput($sformatf("burst tx_ready %0d", i), {31'b0, tx_ready}, {31'b0, expReady});
      if (expReady) expQ.push_back(8'(i));
      @(posedge clk);
      if (i == 0) firstIdx = lineLog.size();
      #1;
      // The idle FSM takes the first word out while the second one goes in.
      occ = occ + (expReady ? 1 : 0) - ((i == 1) ? 1 : 0);
    end
    tx_req  = 1'b0;
    prevS   = 0;
    prevEnd = firstIdx;
    len     = 0;
    foreach (expQ[k]) begin
      findStart($sformatf("burst start %0d", k), prevEnd, 1500, s);
      if (k == 0) checkOutput("burst first latency", s - firstIdx, 32'd1);
      else checkOutput($sformatf("burst spacing %0d", k), s - prevS, len + 1);
      checkFrame($sformatf("burst frame %0d", k), s, expQ[k], 2'b00, 2'b00, 16'd4, len);
      prevS   = s;
      prevEnd = s + len;
    end
    checkSteady("after burst no extra frame", prevEnd, 700, 1'b1);

    // Config change while a frame is in flight
    waitIdle("idle before cfg change");
    cfg_clk_div   = 16'd1;
    cfg_parity    = 2'b00;
    cfg_stop_bits = 2'b00;
    wA     = 8'($urandom);
    wB     = 8'($urandom);
    newPar = 2'($urandom_range(1, 2));
    applyStimulus(wA, p);
    @(posedge clk);
    #1;
    cfg_parity    = newPar;
    cfg_stop_bits = 2'b01;
    applyStimulus(wB, p2);
    findStart("cfgA start", p, 50, s);
    checkFrame("cfg frame A", s, wA, 2'b00, 2'b00, 16'd1, len);
    findStart("cfgB start", s + len, 100, s2);
    checkOutput("cfg frame B gap", s2 - s, len + 1);
    checkFrame("cfg frame B", s2, wB, newPar, 2'b01, 16'd1, len2);

    // Random words with random framing and divider
    for (int r = 0; r < 4; r++) begin
      waitIdle("idle before random");
      wA   = 8'($urandom);
      rPar = 2'($urandom_range(0, 3));
      rStp = 2'($urandom_range(0, 3));
      rDiv = 16'($urandom_range(0, 2));
      cfg_parity    = rPar;
      cfg_stop_bits = rStp;
      cfg_clk_div   = rDiv;
      applyStimulus(wA, p);
      findStart($sformatf("rand%0d start", r), p, 50, s);
      checkOutput($sformatf("rand%0d latency", r), s - p, 32'd1);
      checkFrame($sformatf("rand%0d w=%0h par=%0d stp=%0d div=%0d", r, wA, rPar, rStp, rDiv),
                 s, wA, rPar, rStp, rDiv, len);
      checkOutput($sformatf("rand%0d busy after", r), {31'b0, busyLog[s + len]}, 32'd0);
    end

    // Reset during the data bits of the second of three queued frames
    waitIdle("idle before abort");
    cfg_parity    = 2'b00;
    cfg_stop_bits = 2'b00;
    cfg_clk_div   = 16'd1;
    wA = 8'($urandom);
    applyStimulus(wA, p);
    applyStimulus(8'($urandom), p2);
    applyStimulus(8'($urandom), p2);
    findStart("abort frame1 start", p, 50, s);
    checkFrame("abort frame1", s, wA, 2'b00, 2'b00, 16'd1, len);
    waitLog(s + len + 1 + 16 + 16 * 3 + 5);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort uart_tx", {31'b0, uart_tx}, 32'd1);
    checkOutput("abort tx_busy", {31'b0, tx_busy}, 32'd0);
    checkOutput("abort tx_ready", {31'b0, tx_ready}, 32'd1);
    rst  = 1'b1;
    rIdx = lineLog.size();
    checkSteady("after abort", rIdx, 400, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
